divide_8: RTL and testbench



---
 rtl/div_pkg.sv | 28 ++
 rtl/divide_8_step.sv | 36 +++
 rtl/divide_8.sv | 112 +++++++++++
 tb/tb_divide_8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, state codes and constants for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    localparam int CNT_W = $clog2(DEF_DIVIDEND_W + 1);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam logic [DEF_DIVIDEND_W-1:0] DBZ_QUOTIENT = '1;

    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divide_8_step.sv
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration (shift, compare, subtract).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W+1:0] w_dvs_ext;
    logic [DIVISOR_W:0]   w_diff;
    logic                 w_ge;

    assign w_shift   = {rem_in, bit_in};
    assign w_dvs_ext = {2'b00, divisor};
    assign w_ge      = (w_shift >= w_dvs_ext);
    // Low bits of the difference are exact whenever the subtraction is taken.
    assign w_diff    = w_shift[DIVISOR_W:0] - {1'b0, divisor};

    assign rem_out = w_ge ? w_diff : w_shift[DIVISOR_W:0];
    assign q_bit   = w_ge;

endmodule

`default_nettype wire

// File: rtl/divide_8.sv
// ============================================================================
// Module      : divide_8
// Description : Sequential restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divide_8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] q,
    output logic [DIVISOR_W-1:0]  r,
    output logic                  dbz
);

    localparam int                 C_CNT_W = cnt_width(DIVIDEND_W);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIVIDEND_W - 1);

    state_t                r_state;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_r;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_rem_next;
    logic                  w_q_bit;
    logic [DIVIDEND_W-1:0] w_dvd_next;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_dvd[DIVIDEND_W-1]),
        .divisor (r_dvs),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    // Dividend bits leave at the top while quotient bits fill from the bottom.
    assign w_dvd_next = {r_dvd[DIVIDEND_W-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            r_dvd   <= a;
                            r_dvs   <= b;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_q     <= '1;
                            r_r     <= a[DIVISOR_W-1:0];
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_q     <= w_dvd_next;
                        r_r     <= w_rem_next[DIVISOR_W-1:0];
                        r_dbz   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign q    = r_q;
    assign r    = r_r;
    assign dbz  = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_divide_8.sv
// ============================================================================
// Module      : tb_divide_8
// Description : Randomized self-checking bench for divide_8 against a / and %.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divide_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;

    int n_checks = 0;
    int n_errors = 0;

    divide_8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction; expected results come from integer / and %.
    task automatic run_op(input logic [15:0] ia, input logic [7:0] ib,
                          input bit noise, input string tag);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edbz;
        int          elat;
        int          k;
        int          busy_cnt;
        if (ib == 8'd0) begin
            eq   = 16'hFFFF;
            er   = ia[7:0];
            edbz = 1'b1;
            elat = 0;
        end else begin
            eq   = 16'(int'(ia) / int'(ib));
            er   = 8'(int'(ia) % int'(ib));
            edbz = 1'b0;
            elat = 16;
        end
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(negedge clk);
        start = 1'b0;
        k        = 0;
        busy_cnt = 0;
        while (!done && k < 40) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a     = 16'($urandom);
                b     = 8'($urandom);
            end
            @(negedge clk);
            k++;
        end
        check({tag, "/done_seen"}, 32'(done), 32'd1);
        if (busy) busy_cnt++;
        check({tag, "/latency"}, 32'(k), 32'(elat));
        check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(elat + 1));
        check({tag, "/q"}, 32'(q), 32'(eq));
        check({tag, "/r"}, 32'(r), 32'(er));
        check({tag, "/dbz"}, 32'(dbz), 32'(edbz));
        if (ib != 8'd0) begin
            check({tag, "/recombine"}, 32'(q) * 32'(ib) + 32'(r), 32'(ia));
            check({tag, "/r_lt_b"}, 32'(r < ib), 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check({tag, "/done_once"}, 32'(done), 32'd0);
        check({tag, "/idle_after"}, 32'(busy), 32'd0);
        check({tag, "/q_hold"}, 32'(q), 32'(eq));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [15:0] ra;
        logic [7:0]  rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/q", 32'(q), 32'd0);
        check("reset/r", 32'(r), 32'd0);
        check("reset/dbz", 32'(dbz), 32'd0);
        rst = 1'b0;

        run_op(16'h03E8, 8'h07, 1'b0, "d1000_7");
        run_op(16'hFFFF, 8'hFF, 1'b0, "max_by_ff");
        run_op(16'hFE01, 8'hFF, 1'b0, "mul_max_rt");
        run_op(16'h0005, 8'h09, 1'b0, "small_num");
        run_op(16'h0000, 8'h01, 1'b0, "zero_num");
        run_op(16'h1234, 8'h00, 1'b0, "div_zero");
        run_op(16'h0064, 8'h0A, 1'b0, "dbz_clear");
        run_op(16'h03E8, 8'h07, 1'b1, "busy_noise");

        // Reset while the counter sits at 8 discards the operation.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h03E8;
        b     = 8'h07;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/q", 32'(q), 32'd0);
        check("midrst/r", 32'(r), 32'd0);
        check("midrst/dbz", 32'(dbz), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("midrst/no_done", 32'(pulses), 32'd0);
        run_op(16'h03E8, 8'h07, 1'b0, "after_rst");

        // Reset and start together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h0050;
        b     = 8'h05;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start/busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start/busy2", 32'(busy), 32'd0);
        check("rst_start/q", 32'(q), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, (i % 7) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
